pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch front end of the RISC-V datapath.
- Produces the two next-PC candidates (PC+4 and the branch/jump target) and applies the redirect select `jump | (branch & zero)`.
- Fetches instructions from instruction memory over a req/gnt/rvalid handshake and hands each one to decode with a valid/ready handshake.
- At most one memory request is outstanding at a time.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch  in  1  branch instruction in execute.
- zero  in  1  ALU zero flag for that branch.
- jump  in  1  unconditional jump in execute.
- br_target  in  XLEN  branch/jump target address.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  XLEN  instruction word.
- if_valid  out  1  instruction presented to decode.
- id_ready  in  1  decode accepts the instruction.
- if_instr  out  XLEN  instruction word.
- if_pc  out  XLEN  address of if_instr.
- if_pc_plus4  out  XLEN  if_pc + 4, modulo 2^XLEN.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, pc=RESET_PC, fetch_addr=RESET_PC, kill=0.
  - imem_req=0, if_valid=0.
  - if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, if_pc_plus4=RESET_PC+4.
  - Reset mid-transaction abandons it; any late rvalid is ignored until the next grant.
- redirect = jump | (branch & zero).
  - When redirect is high, pc <= {br_target[XLEN-1:2], 2'b00}; the low two bits are ignored.
  - If several redirects arrive, the latest cycle's target wins.
- Outputs: imem_req is high only in FETCH. imem_addr = fetch_addr.
- FETCH:
  - imem_req=1. fetch_addr and imem_req must stay stable until imem_gnt.
  - On gnt: go to WAIT.
  - A redirect in FETCH (with or without gnt) sets kill=1. The in-flight address is never changed mid-request.
- WAIT:
  - On rvalid with kill=0: capture if_instr=imem_rdata, if_pc=fetch_addr, if_pc_plus4=fetch_addr+4. Go to VALID.
  - On rvalid with kill=1: drop the data, clear kill, fetch_addr <= pc, go to FETCH.
  - A redirect while in WAIT sets kill=1.
  - Redirect and rvalid in the same cycle: the response is dropped.
- VALID:
  - if_valid=1; outputs stay stable while id_ready=0.
  - Redirect (priority over id_ready): if_valid drops next cycle, fetch_addr <= redirect target, go to FETCH.
  - Else if id_ready: pc and fetch_addr <= if_pc_plus4, go to FETCH.
- Latency: 0-wait memory (gnt in the FETCH cycle, rvalid the next cycle) gives if_valid 2 cycles after imem_req first rises. Steady state is one instruction per 3 cycles.
- Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no error is raised.

Decomposition:
- Package riscv_pkg:
  - XLEN
  - RESET_PC
  - INSTR_NOP = 32'h0000_0013
  - fetch_state_t enum {FETCH, WAIT, VALID}
- Sub-module pc_next_sel (combinational):
  - Computes pc_plus4 and redirect.
  - Selects the aligned target or pc_plus4.
  - Instantiated once.

Test Plan:
- Reset release with 0-wait memory returning 0x00500093 at 0x0, id_ready=1 -> if_valid at cycle 2, if_pc=0x0, if_pc_plus4=0x4; next imem_addr=0x4.
- id_ready=0 for 5 cycles while VALID -> if_valid, if_instr and if_pc held stable; no imem_req; fetch of if_pc+4 starts the cycle after id_ready=1.
- branch=1, zero=1, br_target=0x103 while VALID at pc 0x20 -> if_valid low next cycle, imem_addr=0x100; branch=1, zero=0 -> no redirect, next fetch 0x24.
- jump=1, target 0x200, while WAIT at 0x40 -> response for 0x40 dropped (if_valid stays 0), next request at 0x200; a second jump to 0x300 one cycle later -> request at 0x300.
- imem_gnt held low 4 cycles plus a redirect during that stall -> imem_addr unchanged until gnt, response killed, next request to the target.
- Reset asserted during WAIT, then rvalid -> outputs at reset values, rvalid ignored, fetch restarts at RESET_PC; also pc 0xFFFFFFFC -> if_pc_plus4=0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
// master = fetch unit, slave = memory / decode side.
interface pc_fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            if_valid;
  logic            id_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output id_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC candidate generation: sequential PC+4 versus the aligned
// branch/jump target, selected by the execute-stage redirect.
module pc_next_sel #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic [XLEN-1:0] next_pc
);

  // Candidate select; the target's low two bits are discarded.
  always_comb begin
    pc_plus4 = pc + XLEN'(4);
    redirect = jump | (branch & zero);
    next_pc  = redirect ? {br_target[XLEN-1:2], 2'b00} : pc_plus4;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch front end. Issues one memory
// request at a time, presents each returned word to decode, and discards
// responses that were overtaken by a redirect.
module pc_fetch_unit #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                branch,
  input  logic                zero,
  input  logic                jump,
  input  logic [XLEN-1:0]     br_target,
  pc_fetch_unit_if.master     bus
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc_plus4_q, if_pc_plus4_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;

  // fetch_addr is the base: in VALID it equals if_pc, so pc_plus4 is if_pc + 4.
  pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .pc        (fetch_addr_q),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .br_target (br_target),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .next_pc   (next_pc)
  );

  // Fetch sequencing, kill tracking and decode-register capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    kill_d        = kill_q;
    instr_d       = instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;

    if (redirect) begin
      pc_d = next_pc;
    end

    unique case (state_q)
      FETCH: begin
        // Address stays put until granted; the stale response is dropped later.
        if (redirect) begin
          kill_d = 1'b1;
        end
        if (bus.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d       = 1'b0;
            fetch_addr_d = redirect ? next_pc : pc_q;
            state_d      = FETCH;
          end else begin
            instr_d       = bus.imem_rdata;
            if_pc_d       = fetch_addr_q;
            if_pc_plus4_d = pc_plus4;
            state_d       = VALID;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      VALID: begin
        // Redirect wins over id_ready; next_pc already encodes that priority.
        if (redirect || bus.id_ready) begin
          pc_d         = next_pc;
          fetch_addr_d = next_pc;
          state_d      = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC;
      kill_q        <= 1'b0;
      instr_q       <= XLEN'(INSTR_NOP);
      if_pc_q       <= RESET_PC;
      if_pc_plus4_q <= RESET_PC + XLEN'(4);
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      kill_q        <= kill_d;
      instr_q       <= instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
    end
  end

  // Request is masked while reset is held so the bus is quiet during reset.
  always_comb begin
    bus.imem_req    = rst_n && (state_q == FETCH);
    bus.imem_addr   = fetch_addr_q;
    bus.if_valid    = (state_q == VALID);
    bus.if_instr    = instr_q;
    bus.if_pc       = if_pc_q;
    bus.if_pc_plus4 = if_pc_plus4_q;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory responder, instruction-stream model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] br_target = 32'h0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .branch    (branch),
    .zero      (zero),
    .jump      (jump),
    .br_target (br_target),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory image: distinct word per address, 0x00500093 at address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[23:0], 8'h00};
  endfunction

  // ---------------- memory responder ----------------
  int          gnt_wait = 0;
  int          rv_delay = 0;
  int          stall_cnt = 0;
  int          rv_cnt = 0;
  bit          pending = 1'b0;
  bit          req_seen = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] addr_seen = 32'h0;

  initial begin
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      // Handshake that completed at the last rising edge.
      if (bus.imem_gnt && req_seen) begin
        pending   = 1'b1;
        pend_addr = addr_seen;
        rv_cnt    = rv_delay;
      end
      bus.imem_rvalid = 1'b0;
      if (pending) begin
        if (rv_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
          pending         = 1'b0;
        end else begin
          rv_cnt--;
        end
      end
      req_seen     = bus.imem_req;
      addr_seen    = bus.imem_addr;
      bus.imem_gnt = 1'b0;
      if (bus.imem_req && !pending) begin
        if (stall_cnt >= gnt_wait) begin
          bus.imem_gnt = 1'b1;
          stall_cnt    = 0;
        end else begin
          stall_cnt++;
        end
      end
    end
  end

  // ---------------- stream model and compare ----------------
  // Each instruction shown to decode must be the one at the expected PC:
  // RESET_PC after reset, the latest aligned redirect target, else previous + 4.
  logic [31:0] exp_pc = RST_PC;
  logic        prev_stall = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  initial begin
    logic redir;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_pc     = RST_PC;
        prev_stall = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("req_held", {31'b0, bus.imem_req}, 32'd1);
          check("addr_held", bus.imem_addr, prev_addr);
        end
        if (prev_hold) check("valid_held", {31'b0, bus.if_valid}, 32'd1);
        if (bus.imem_req) check("addr_align", {30'b0, bus.imem_addr[1:0]}, 32'd0);
        if (bus.if_valid) begin
          check("model_pc", bus.if_pc, exp_pc);
          check("model_instr", bus.if_instr, mem_word(exp_pc));
          check("model_pc4", bus.if_pc_plus4, exp_pc + 32'd4);
        end
        redir      = jump | (branch & zero);
        prev_stall = bus.imem_req && !bus.imem_gnt;
        prev_addr  = bus.imem_addr;
        prev_hold  = bus.if_valid && !bus.id_ready && !redir;
        if (redir) exp_pc = {br_target[31:2], 2'b00};
        else if (bus.if_valid && bus.id_ready) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_valid(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.if_valid && n < max);
    check("wait_valid", {31'b0, bus.if_valid}, 32'd1);
  endtask

  task automatic wait_req(input logic [31:0] a, input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.imem_req && bus.imem_addr == a) && n < max);
    check("wait_req", {31'b0, bus.imem_req}, 32'd1);
    check("wait_req_addr", bus.imem_addr, a);
  endtask

  task automatic check_reset_values();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    check("rst_instr", bus.if_instr, 32'h0000_0013);
    check("rst_pc", bus.if_pc, 32'h0000_0000);
    check("rst_pc4", bus.if_pc_plus4, 32'h0000_0004);
  endtask

  initial begin
    int lat;
    bus.id_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset release, zero-wait memory: valid two cycles after req rises.
    @(negedge clk);
    check("first_req", {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.if_valid && lat < 10);
    check("first_latency", lat, 32'd2);
    check("first_pc", bus.if_pc, 32'h0);
    check("first_pc4", bus.if_pc_plus4, 32'h4);
    check("first_instr", bus.if_instr, 32'h0050_0093);
    @(negedge clk);
    check("second_addr", bus.imem_addr, 32'h4);

    // Decode stall for 5 cycles.
    wait_valid(20);
    bus.id_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", {31'b0, bus.if_valid}, 32'd1);
      check("stall_noreq", {31'b0, bus.imem_req}, 32'd0);
    end
    check("stall_pc", bus.if_pc, 32'h4);
    check("stall_instr", bus.if_instr, mem_word(32'h4));
    bus.id_ready = 1'b1;
    @(negedge clk);
    check("resume_req", {31'b0, bus.imem_req}, 32'd1);
    check("resume_addr", bus.imem_addr, 32'h8);

    // Taken branch with unaligned target while VALID at 0x20.
    wait_valid(20);
    jump = 1'b1; br_target = 32'h20;
    @(negedge clk);
    jump = 1'b0;
    check("jmp20_addr", bus.imem_addr, 32'h20);
    wait_valid(20);
    check("at20_pc", bus.if_pc, 32'h20);
    branch = 1'b1; zero = 1'b1; br_target = 32'h103;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    check("taken_valid", {31'b0, bus.if_valid}, 32'd0);
    check("taken_addr", bus.imem_addr, 32'h100);
    // Not-taken branch at 0x20.
    wait_valid(20);
    jump = 1'b1; br_target = 32'h20;
    @(negedge clk);
    jump = 1'b0;
    wait_valid(20);
    branch = 1'b1; zero = 1'b0; br_target = 32'h103;
    @(negedge clk);
    branch = 1'b0;
    check("ntaken_req", {31'b0, bus.imem_req}, 32'd1);
    check("ntaken_addr", bus.imem_addr, 32'h24);

    // Jump while WAIT at 0x40, then a second jump one cycle later.
    wait_valid(20);
    jump = 1'b1; br_target = 32'h40;
    @(negedge clk);
    jump = 1'b0;
    check("req40_addr", bus.imem_addr, 32'h40);
    @(negedge clk);
    check("wait40_noreq", {31'b0, bus.imem_req}, 32'd0);
    jump = 1'b1; br_target = 32'h200;
    @(negedge clk);
    check("req200_addr", bus.imem_addr, 32'h200);
    check("drop40_valid", {31'b0, bus.if_valid}, 32'd0);
    br_target = 32'h300;
    @(negedge clk);
    jump = 1'b0;
    wait_req(32'h300, 20);
    wait_valid(20);
    check("at300_pc", bus.if_pc, 32'h300);

    // Grant stalled 4 cycles with a redirect during the stall.
    gnt_wait = 4;
    @(negedge clk);
    check("stall_addr0", bus.imem_addr, 32'h304);
    @(negedge clk);
    check("stall_addr1", bus.imem_addr, 32'h304);
    jump = 1'b1; br_target = 32'h500;
    @(negedge clk);
    jump = 1'b0;
    check("stall_addr2", bus.imem_addr, 32'h304);
    @(negedge clk);
    check("stall_addr3", bus.imem_addr, 32'h304);
    wait_req(32'h500, 30);
    gnt_wait = 0;
    wait_valid(30);
    check("at500_pc", bus.if_pc, 32'h500);

    // Reset during WAIT with a late response arriving afterwards.
    rv_delay = 3;
    @(negedge clk);
    check("req504_addr", bus.imem_addr, 32'h504);
    @(negedge clk);
    gnt_wait = 1000;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("late_valid", {31'b0, bus.if_valid}, 32'd0);
      check("restart_addr", bus.imem_addr, 32'h0);
    end
    rv_delay = 0;
    gnt_wait = 0;
    wait_valid(20);
    check("restart_pc", bus.if_pc, 32'h0);
    check("restart_instr", bus.if_instr, 32'h0050_0093);

    // Wrap-around at the top of the address space.
    jump = 1'b1; br_target = 32'hFFFF_FFFF;
    @(negedge clk);
    jump = 1'b0;
    check("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
    wait_valid(20);
    check("top_pc", bus.if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", bus.if_pc_plus4, 32'h0);
    @(negedge clk);
    check("wrap_addr", bus.imem_addr, 32'h0);
    wait_valid(20);
    check("wrap_pc", bus.if_pc, 32'h0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
